// File: rtl/level_pkg.sv
// Shared types and constants for the multi-level claw/loot controller:
// FSM state encoding, sound codes and the default loot table lookups.
package level_pkg;

  typedef enum logic [2:0] {
    IDLE_ST      = 3'd0,
    SWING_ST     = 3'd1,
    DOWN_ST      = 3'd2,
    HOLD_ST      = 3'd3,
    BACK_ST      = 3'd4,
    LEVEL_END_ST = 3'd5,
    GAME_END_ST  = 3'd6
  } state_e;

  localparam logic [3:0] SND_NONE = 4'd0;
  localparam logic [3:0] SND_WIN  = 4'd1;
  localparam logic [3:0] SND_LOSS = 4'd2;
  localparam logic [3:0] SND_CLAW = 4'd3;

  // Default loot table: 0 none, 1 gold, 2 rock, 3 diamond; unknown types read as "none".
  function automatic logic [15:0] loot_score(input logic [7:0] idx);
    case (idx)
      8'd1:    return 16'd10;
      8'd2:    return 16'd2;
      8'd3:    return 16'd50;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [7:0] loot_speed(input logic [7:0] idx);
    case (idx)
      8'd2:    return 8'd2;
      8'd3:    return 8'd6;
      default: return 8'd4;
    endcase
  endfunction

  function automatic logic [3:0] loot_sound(input logic [7:0] idx);
    case (idx)
      8'd1:    return 4'd4;
      8'd2:    return 4'd5;
      8'd3:    return 4'd6;
      default: return SND_NONE;
    endcase
  endfunction

endpackage

// File: rtl/level_score_acc.sv
// Score/level bookkeeping: saturating score accumulator, level counter and
// the registered goal derived from the level index.
module level_score_acc #(
  parameter int SCORE_W    = 14,
  parameter int NUM_LEVELS = 4,
  parameter int BASE_GOAL  = 20,
  parameter int GOAL_STEP  = 30,
  parameter int LVL_W      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               score_clr_i,
  input  logic               add_en_i,
  input  logic [SCORE_W-1:0] add_val_i,
  input  logic               level_clr_i,
  input  logic               level_inc_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] goal_o,
  output logic [LVL_W-1:0]   level_o
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  function automatic logic [SCORE_W-1:0] goal_of(input logic [LVL_W-1:0] lvl);
    logic [31:0] g;
    g = 32'(BASE_GOAL) + 32'(lvl) * 32'(GOAL_STEP);
    return (g > 32'(SCORE_MAX)) ? SCORE_MAX : g[SCORE_W-1:0];
  endfunction

  logic [SCORE_W-1:0] score_q, score_d, goal_q, goal_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SCORE_W:0]   sum;

  assign sum = {1'b0, score_q} + {1'b0, add_val_i};

  always_comb begin
    score_d = score_q;
    level_d = level_q;
    if (level_clr_i)      level_d = '0;
    else if (level_inc_i) level_d = level_q + LVL_W'(1);
    if (score_clr_i)      score_d = '0;
    else if (add_en_i)    score_d = sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    goal_d = goal_of(level_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      level_q <= '0;
      goal_q  <= goal_of('0);
    end else begin
      score_q <= score_d;
      level_q <= level_d;
      goal_q  <= goal_d;
    end
  end

  assign score_o = score_q;
  assign goal_o  = goal_q;
  assign level_o = level_q;

endmodule

// File: rtl/level_fsm_multi.sv
// Multi-level claw/loot game controller: claw cycle FSM, loot scoring, level sequencing
// and one-cycle collision/sound pulses. Optional held-loot drop: define LOOT_DROP_EN.
module level_fsm_multi
  import level_pkg::*;
#(
  parameter int NUM_LOOT   = 4,
  parameter int LOOT_W     = 3,
  parameter int SCORE_W    = 14,
  parameter int SPEED_W    = 4,
  parameter int NUM_LEVELS = 4,
  parameter int BASE_GOAL  = 20,
  parameter int GOAL_STEP  = 30,
  parameter int DEF_SPEED  = 4,
  localparam int LVL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic               claw_dr,
  input  logic               borders_dr,
  input  logic               loot_dr,
  input  logic [LOOT_W-1:0]  loot_type,
  input  logic               timer_ended,
  input  logic               is_enter_pressed,
  input  logic               claw_returned,
  input  logic               release_loot,
  output logic               claw_collision,
  output logic               loot_collision,
  output logic [SPEED_W-1:0] move_speed,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] goal,
  output logic [LVL_W-1:0]   level,
  output logic               start_timer,
  output logic               level_ended,
  output logic               game_won,
  output logic [3:0]         sound_request,
  output logic               play_sound
);

  state_e             state_q, state_d;
  logic [LOOT_W-1:0]  held_q, held_d, in_type, latch_type;
  logic               loot_flag_q, loot_flag_d, hold_entry_q, hold_entry_d;
  logic               claw_col_q, claw_col_d, loot_col_q, loot_col_d;
  logic               start_timer_q, start_timer_d, play_q, play_d, won_q, won_d;
  logic [3:0]         snd_q, snd_d, end_snd;
  logic [SPEED_W-1:0] speed;
  logic               score_clr, add_en, level_clr, level_inc;
  logic [SCORE_W-1:0] add_val, score_w, goal_w;
  logic [LVL_W-1:0]   level_w;
  logic               met, last_level, drop;

  assign in_type    = (int'(loot_type) < NUM_LOOT) ? loot_type : '0;
  assign latch_type = loot_flag_q ? in_type : '0;
  assign met        = (score_w >= goal_w);
  assign last_level = (level_w == LVL_W'(NUM_LEVELS - 1));
  assign end_snd    = met ? SND_WIN : SND_LOSS;

`ifdef LOOT_DROP_EN
  assign drop = release_loot && (held_q != '0);
`else
  logic unused_release;
  assign unused_release = release_loot;
  assign drop = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d       = state_q;
    held_d        = held_q;
    loot_flag_d   = loot_flag_q;
    hold_entry_d  = 1'b0;
    claw_col_d    = 1'b0;
    loot_col_d    = 1'b0;
    start_timer_d = 1'b0;
    play_d        = 1'b0;
    snd_d         = SND_NONE;
    won_d         = won_q;
    speed         = '0;
    score_clr     = 1'b0;
    add_en        = 1'b0;
    add_val       = '0;
    level_clr     = 1'b0;
    level_inc     = 1'b0;
    case (state_q)
      IDLE_ST, GAME_END_ST: begin
        if (state_q == IDLE_ST) begin
          score_clr   = 1'b1;
          held_d      = '0;
          loot_flag_d = 1'b0;
        end
        if (start_game) begin
          state_d       = SWING_ST;
          level_clr     = 1'b1;
          score_clr     = 1'b1;
          held_d        = '0;
          loot_flag_d   = 1'b0;
          start_timer_d = 1'b1;
          won_d         = 1'b0;
        end
      end
      SWING_ST, DOWN_ST: begin
        speed = SPEED_W'(DEF_SPEED);
        if (timer_ended) begin
          state_d = LEVEL_END_ST;
          play_d  = 1'b1;
          snd_d   = end_snd;
        end else if (state_q == SWING_ST) begin
          if (is_enter_pressed) begin
            state_d = DOWN_ST;
            play_d  = 1'b1;
            snd_d   = SND_CLAW;
          end
        end else if (claw_dr && (borders_dr || loot_dr)) begin
          state_d      = HOLD_ST;
          hold_entry_d = 1'b1;
          claw_col_d   = 1'b1;
          loot_col_d   = loot_dr;
          loot_flag_d  = loot_dr;
        end
      end
      HOLD_ST: begin
        // The entry cycle only latches the catch; a frame tick there is deliberately dropped.
        if (hold_entry_q) begin
          held_d      = latch_type;
          loot_flag_d = 1'b0;
          snd_d       = loot_sound(8'(latch_type));
          play_d      = (snd_d != SND_NONE);
        end else if (startOfFrame) begin
          state_d = BACK_ST;
        end
      end
      BACK_ST: begin
        speed = (held_q == '0) ? SPEED_W'(DEF_SPEED) : SPEED_W'(loot_speed(8'(held_q)));
        if (drop) held_d = '0;
        if (claw_returned) begin
          state_d = SWING_ST;
          add_en  = 1'b1;
          add_val = drop ? '0 : SCORE_W'(loot_score(8'(held_q)));
          held_d  = '0;
        end
      end
      LEVEL_END_ST: begin
        if (!met) begin
          state_d = GAME_END_ST;
          won_d   = 1'b0;
        end else if (last_level) begin
          state_d = GAME_END_ST;
          won_d   = 1'b1;
        end else if (is_enter_pressed) begin
          state_d       = SWING_ST;
          level_inc     = 1'b1;
          score_clr     = 1'b1;
          start_timer_d = 1'b1;
        end
      end
      default: state_d = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE_ST;
      held_q        <= '0;
      loot_flag_q   <= 1'b0;
      hold_entry_q  <= 1'b0;
      claw_col_q    <= 1'b0;
      loot_col_q    <= 1'b0;
      start_timer_q <= 1'b0;
      play_q        <= 1'b0;
      snd_q         <= SND_NONE;
      won_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q       <= state_d;
      held_q        <= held_d;
      loot_flag_q   <= loot_flag_d;
      hold_entry_q  <= hold_entry_d;
      claw_col_q    <= claw_col_d;
      loot_col_q    <= loot_col_d;
      start_timer_q <= start_timer_d;
      play_q        <= play_d;
      snd_q         <= snd_d;
      won_q         <= won_d;
    end
  end

  level_score_acc #(
    .SCORE_W   (SCORE_W),
    .NUM_LEVELS(NUM_LEVELS),
    .BASE_GOAL (BASE_GOAL),
    .GOAL_STEP (GOAL_STEP),
    .LVL_W     (LVL_W)
  ) u_score_acc (
    .clk        (clk),
    .rst_n      (resetN),
    .score_clr_i(score_clr),
    .add_en_i   (add_en),
    .add_val_i  (add_val),
    .level_clr_i(level_clr),
    .level_inc_i(level_inc),
    .score_o    (score_w),
    .goal_o     (goal_w),
    .level_o    (level_w)
  );

  assign claw_collision = claw_col_q;
  assign loot_collision = loot_col_q;
  assign move_speed     = speed;
  assign score          = score_w;
  assign goal           = goal_w;
  assign level          = level_w;
  assign start_timer    = start_timer_q;
  assign level_ended    = (state_q == LEVEL_END_ST) || (state_q == GAME_END_ST);
  assign game_won       = won_q;
  assign sound_request  = snd_q;
  assign play_sound     = play_q;

endmodule

// File: tb/tb_level_fsm_multi.sv
// Self-checking bench for level_fsm_multi: a scripted vector table, random catches
// against a loot-table score model, and hand-written reset/level/saturation sequences.
module tb_level_fsm_multi;

`ifdef LOOT_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  localparam int SCORE_MAX = 16383;

  logic clk = 1'b0;
  logic resetN, startOfFrame, start_game, claw_dr, borders_dr, loot_dr;
  logic [2:0] loot_type;
  logic timer_ended, is_enter_pressed, claw_returned, release_loot;
  logic claw_collision, loot_collision, start_timer, level_ended, game_won, play_sound;
  logic [3:0]  move_speed, sound_request;
  logic [13:0] score, goal;
  logic [1:0]  level;

  level_fsm_multi dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
    .claw_dr(claw_dr), .borders_dr(borders_dr), .loot_dr(loot_dr), .loot_type(loot_type),
    .timer_ended(timer_ended), .is_enter_pressed(is_enter_pressed),
    .claw_returned(claw_returned), .release_loot(release_loot),
    .claw_collision(claw_collision), .loot_collision(loot_collision),
    .move_speed(move_speed), .score(score), .goal(goal), .level(level),
    .start_timer(start_timer), .level_ended(level_ended), .game_won(game_won),
    .sound_request(sound_request), .play_sound(play_sound)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_score  = 0;
  int tbl_score [4] = '{0, 10, 2, 50};
  int tbl_speed [4] = '{4, 4, 2, 6};
  int tbl_sound [4] = '{0, 4, 5, 6};

  typedef struct {
    bit st, en, cl, bo, lo, sof, ret, rel;
    logic [2:0]  lt;
    logic [25:0] exp;
  } vec_t;
  vec_t vecs [19];

  function automatic vec_t mkv(input bit st, en, cl, bo, lo, sof, ret, rel, input int lt,
                               input bit cc, lc, pl, input int snd, spd, scr, input bit stt);
    vec_t v;
    v.st = st; v.en = en; v.cl = cl; v.bo = bo; v.lo = lo; v.sof = sof; v.ret = ret; v.rel = rel;
    v.lt  = 3'(lt);
    v.exp = {cc, lc, pl, 4'(snd), 4'(spd), 14'(scr), stt};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    startOfFrame = 0; start_game = 0; claw_dr = 0; borders_dr = 0; loot_dr = 0;
    loot_type = 3'd0; timer_ended = 0; is_enter_pressed = 0; claw_returned = 0; release_loot = 0;
  endtask

  // One full claw cycle from SWING_ST back to SWING_ST; expectations come from the loot table.
  task automatic catch_loot(input bit hit_loot, input int t, input int hold_wait, input bit rel);
    int eff, held, exp_snd, exp_spd;
    eff  = (t < 4) ? t : 0;
    held = hit_loot ? eff : 0;
    is_enter_pressed = 1; step(); is_enter_pressed = 0;
    check("claw_snd", 32'({play_sound, sound_request}), 32'({1'b1, 4'd3}));
    claw_dr = 1; loot_dr = hit_loot; borders_dr = !hit_loot; loot_type = 3'(t);
    step();
    claw_dr = 0; loot_dr = 0; borders_dr = 0;
    check("collide", 32'({claw_collision, loot_collision}), 32'({1'b1, hit_loot}));
    step();
    exp_snd = tbl_sound[held];
    check("hold_snd", 32'({claw_collision, loot_collision, play_sound, sound_request}),
          32'({2'b00, exp_snd != 0, 4'(exp_snd)}));
    for (int i = 0; i < hold_wait; i++) step();
    startOfFrame = 1; step(); startOfFrame = 0;
    exp_spd = (held == 0) ? 4 : tbl_speed[held];
    check("back_spd", 32'(move_speed), exp_spd);
    if (rel) begin
      release_loot = 1; step(); release_loot = 0;
      if (DROP) held = 0;
      exp_spd = (held == 0) ? 4 : tbl_speed[held];
      check("rel_spd", 32'(move_speed), exp_spd);
    end
    claw_returned = 1; step(); claw_returned = 0;
    m_score = m_score + tbl_score[held];
    if (m_score > SCORE_MAX) m_score = SCORE_MAX;
    check("score", 32'(score), m_score);
  endtask

  task automatic level_up(input int lvl, input int gl);
    timer_ended = 1; step(); timer_ended = 0;
    check("win_snd", 32'({play_sound, sound_request, level_ended}), 32'({1'b1, 4'd1, 1'b1}));
    is_enter_pressed = 1; step(); is_enter_pressed = 0;
    m_score = 0;
    check("next_level", 32'(level), lvl);
    check("next_goal", 32'(goal), gl);
    check("next_score_tmr", 32'({score, start_timer}), 32'({14'd0, 1'b1}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    resetN = 1;
    #2 resetN = 0;
    #1;
    check("reset_outs", 32'({claw_collision, loot_collision, move_speed, score, level, start_timer,
                             level_ended, game_won, sound_request, play_sound}), 0);
    check("reset_goal", 32'(goal), 20);
    repeat (2) @(posedge clk);
    #1 resetN = 1;

    // start, gold catch, border-only hit, rock catch with optional drop
    vecs[0]  = mkv(1,0,0,0,0,0,0,0, 0, 0,0,0, 0,4,0, 1);
    vecs[1]  = mkv(0,0,0,0,0,0,0,0, 0, 0,0,0, 0,4,0, 0);
    vecs[2]  = mkv(0,1,0,0,0,0,0,0, 0, 0,0,1, 3,4,0, 0);
    vecs[3]  = mkv(0,0,1,0,1,0,0,0, 1, 1,1,0, 0,0,0, 0);
    vecs[4]  = mkv(0,0,0,0,0,0,0,0, 1, 0,0,1, 4,0,0, 0);
    vecs[5]  = mkv(0,0,0,0,0,1,0,0, 1, 0,0,0, 0,4,0, 0);
    vecs[6]  = mkv(1,0,0,0,0,0,0,0, 1, 0,0,0, 0,4,0, 0);
    vecs[7]  = mkv(0,0,0,0,0,0,1,0, 1, 0,0,0, 0,4,10, 0);
    vecs[8]  = mkv(0,1,0,0,0,0,0,0, 0, 0,0,1, 3,4,10, 0);
    vecs[9]  = mkv(0,0,1,1,0,0,0,0, 1, 1,0,0, 0,0,10, 0);
    vecs[10] = mkv(0,0,0,0,0,0,0,0, 1, 0,0,0, 0,0,10, 0);
    vecs[11] = mkv(0,0,0,0,0,1,0,0, 1, 0,0,0, 0,4,10, 0);
    vecs[12] = mkv(0,0,0,0,0,0,1,0, 1, 0,0,0, 0,4,10, 0);
    vecs[13] = mkv(0,1,0,0,0,0,0,0, 0, 0,0,1, 3,4,10, 0);
    vecs[14] = mkv(0,0,1,0,1,0,0,0, 2, 1,1,0, 0,0,10, 0);
    vecs[15] = mkv(0,0,0,0,0,1,0,0, 2, 0,0,1, 5,0,10, 0);
    vecs[16] = mkv(0,0,0,0,0,1,0,0, 2, 0,0,0, 0,2,10, 0);
    vecs[17] = mkv(0,0,0,0,0,0,0,1, 2, 0,0,0, 0,DROP ? 4 : 2,10, 0);
    vecs[18] = mkv(0,0,0,0,0,0,1,0, 2, 0,0,0, 0,4,DROP ? 10 : 12, 0);
    for (int i = 0; i < 19; i++) begin
      start_game = vecs[i].st; is_enter_pressed = vecs[i].en; claw_dr = vecs[i].cl;
      borders_dr = vecs[i].bo; loot_dr = vecs[i].lo; startOfFrame = vecs[i].sof;
      claw_returned = vecs[i].ret; release_loot = vecs[i].rel; loot_type = vecs[i].lt;
      step();
      check($sformatf("vec%0d", i), 32'({claw_collision, loot_collision, play_sound, sound_request,
                                         move_speed, score, start_timer}), 32'(vecs[i].exp));
    end
    idle_inputs();
    m_score = DROP ? 10 : 12;

    // one more gold, then level 0 goal met -> level 1
    catch_loot(1'b1, 1, 0, 1'b0);
    level_up(1, 50);
    step();
    check("tmr_pulse_once", 32'(start_timer), 0);

    for (int k = 0; k < 40; k++)
      catch_loot(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // reset while returning with a diamond
    is_enter_pressed = 1; step(); is_enter_pressed = 0;
    claw_dr = 1; loot_dr = 1; loot_type = 3'd3; step(); claw_dr = 0; loot_dr = 0;
    step();
    startOfFrame = 1; step(); startOfFrame = 0;
    check("pre_reset_spd", 32'(move_speed), 6);
    #2 resetN = 0;
    #1;
    check("midback_reset_outs", 32'({claw_collision, loot_collision, move_speed, score, level,
                                     start_timer, level_ended, game_won, sound_request, play_sound}), 0);
    check("midback_reset_goal", 32'(goal), 20);
    @(posedge clk); #1 resetN = 1;
    step();
    check("idle_after_reset", 32'({move_speed, start_timer, level_ended, score}), 0);
    m_score = 0;

    // loss: timer beats enter in SWING_ST, score 0 < goal 20
    start_game = 1; step(); start_game = 0;
    check("start_pulse", 32'({start_timer, level}), 32'({1'b1, 2'd0}));
    timer_ended = 1; is_enter_pressed = 1; step(); timer_ended = 0; is_enter_pressed = 0;
    check("loss_snd", 32'({play_sound, sound_request, level_ended}), 32'({1'b1, 4'd2, 1'b1}));
    step();
    check("loss_end", 32'({level_ended, game_won, move_speed}), 32'({1'b1, 1'b0, 4'd0}));
    start_game = 1; step(); start_game = 0;
    check("restart", 32'({start_timer, level_ended, level}), 32'({1'b1, 1'b0, 2'd0}));

    // full game to the last level with a saturating score
    catch_loot(1'b1, 1, 1, 1'b0);
    catch_loot(1'b1, 1, 0, 1'b0);
    level_up(1, 50);
    catch_loot(1'b1, 3, 0, 1'b0);
    level_up(2, 80);
    catch_loot(1'b1, 3, 0, 1'b0);
    catch_loot(1'b1, 3, 2, 1'b0);
    level_up(3, 110);
    for (int k = 0; k < 330; k++) catch_loot(1'b1, 3, 0, 1'b0);
    check("saturated", 32'(score), SCORE_MAX);
    timer_ended = 1; step(); timer_ended = 0;
    check("final_snd", 32'({play_sound, sound_request, game_won}), 32'({1'b1, 4'd1, 1'b0}));
    step();
    check("game_won", 32'({game_won, level_ended}), 32'({1'b1, 1'b1}));
    start_game = 1; step(); start_game = 0;
    check("new_game", 32'({game_won, level, start_timer, score}), 32'({1'b0, 2'd0, 1'b1, 14'd0}));
    check("new_game_goal", 32'(goal), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
